// File: rtl/instr_stream_encoder.sv
// instr_stream_encoder: packs op/cmd/reg/imm bundles into 32-bit words and streams them into
// instruction memory, then appends NOP padding so the pipeline drains cleanly.
module instr_stream_encoder #(
    parameter int DEPTH    = 64,
    parameter int AW       = $clog2(DEPTH),
    parameter int PAD_NOPS = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          finish,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_op,
    input  logic [4:0]    in_cmd,
    input  logic          in_imm_flag,
    input  logic [3:0]    in_rd,
    input  logic [3:0]    in_rn,
    input  logic [3:0]    in_rm,
    input  logic [23:0]   in_imm,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          busy,
    output logic          done,
    output logic          err_illegal,
    output logic          err_overflow,
    output logic [AW:0]   word_count
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_PAD  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam int PW = $clog2(PAD_NOPS + 2);

    logic [1:0]    r_state;
    logic [AW:0]   r_ptr;
    logic [AW:0]   r_wcnt;
    logic [PW-1:0] r_pad;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_wdata;
    logic          r_done;
    logic          r_err_ill;
    logic          r_err_ovf;

    logic          w_not_full;
    logic          w_hs;
    logic          w_illegal;
    logic [31:0]   w_word;

    always_comb begin
        w_not_full = r_ptr < (AW+1)'(DEPTH);
        in_ready   = (r_state == S_LOAD) && w_not_full;
        w_hs       = in_valid && in_ready;
        w_illegal  = (in_op == 2'b11) || (in_op == 2'b00 && in_cmd > 5'd12);
        w_word     = (in_op == 2'b00) ? {in_op, in_imm_flag, in_cmd, in_rd, in_rn,
                                         in_imm_flag ? in_imm[15:0] : {in_rm, 12'h0}} :
                     (in_op == 2'b01) ? {in_op, 1'b0, in_cmd[1:0], 3'b0, in_rd, in_rn, in_imm[15:0]} :
                                        {in_op, in_cmd[0], 5'b0, in_imm};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_wcnt    <= '0;
            r_pad     <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_done    <= 1'b0;
            r_err_ill <= 1'b0;
            r_err_ovf <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (r_we)
                r_wcnt <= r_wcnt + 1'b1;
            case (r_state)
                S_LOAD: begin
                    if (w_hs && w_illegal)
                        r_err_ill <= 1'b1;
                    else if (w_hs) begin
                        r_we    <= 1'b1;
                        r_addr  <= r_ptr[AW-1:0];
                        r_wdata <= w_word;
                        r_ptr   <= r_ptr + 1'b1;
                    end
                    if (in_valid && !w_not_full)
                        r_err_ovf <= 1'b1;
                    if (finish) begin
                        r_state <= S_PAD;
                        r_pad   <= '0;
                    end
                end
                S_PAD: begin
                    if (r_pad < PW'(PAD_NOPS) && w_not_full) begin
                        r_we    <= 1'b1;
                        r_addr  <= r_ptr[AW-1:0];
                        r_wdata <= 32'h0;
                        r_ptr   <= r_ptr + 1'b1;
                        r_pad   <= r_pad + 1'b1;
                    end else begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE: only start matters; clearing here overrides the count update above
                    if (start) begin
                        r_state   <= S_LOAD;
                        r_ptr     <= '0;
                        r_wcnt    <= '0;
                        r_done    <= 1'b0;
                        r_err_ill <= 1'b0;
                        r_err_ovf <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign imem_we      = r_we;
    assign imem_addr    = r_addr;
    assign imem_wdata   = r_wdata;
    assign busy         = (r_state == S_LOAD) || (r_state == S_PAD) || r_we;
    assign done         = r_done;
    assign err_illegal  = r_err_ill;
    assign err_overflow = r_err_ovf;
    assign word_count   = r_wcnt;
endmodule

// File: tb/tb_instr_stream_encoder.sv
// tb_instr_stream_encoder: directed vector table for encoding plus hand-written sequences for
// padding, overflow, ignored controls and mid-operation reset.
module tb_instr_stream_encoder;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          clk = 1'b0;
    logic          rst, start, finish, in_valid, in_ready, in_imm_flag;
    logic [1:0]    in_op;
    logic [4:0]    in_cmd;
    logic [3:0]    in_rd, in_rn, in_rm;
    logic [23:0]   in_imm;
    logic          imem_we, busy, done, err_illegal, err_overflow;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   word_count;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  cmd;
        logic        f;
        logic [3:0]  rd, rn, rm;
        logic [23:0] imm;
        logic        legal;
        logic [31:0] word;
    } vec_t;
    vec_t v[11];

    instr_stream_encoder #(.DEPTH(DEPTH), .AW(AW), .PAD_NOPS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_cmd(in_cmd),
        .in_imm_flag(in_imm_flag), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .err_illegal(err_illegal), .err_overflow(err_overflow),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t x);
        in_valid = 1'b1; in_op = x.op; in_cmd = x.cmd; in_imm_flag = x.f;
        in_rd = x.rd; in_rn = x.rn; in_rm = x.rm; in_imm = x.imm;
    endtask

    task automatic begin_prog;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    initial begin
        v[0]  = '{2'd0, 5'd4,  1'b0, 4'd1, 4'd2, 4'd3, 24'h0,      1'b1, 32'h0412_3000};
        v[1]  = '{2'd0, 5'd7,  1'b1, 4'd5, 4'd0, 4'd0, 24'h0000FF, 1'b1, 32'h2750_00FF};
        v[2]  = '{2'd1, 5'd0,  1'b0, 4'd2, 4'd3, 4'd0, 24'h000010, 1'b1, 32'h4023_0010};
        v[3]  = '{2'd2, 5'd1,  1'b0, 4'd0, 4'd0, 4'd0, 24'h000100, 1'b1, 32'hA000_0100};
        v[4]  = '{2'd0, 5'd13, 1'b0, 4'd1, 4'd2, 4'd3, 24'h0,      1'b0, 32'h0};
        v[5]  = '{2'd3, 5'd0,  1'b0, 4'd1, 4'd2, 4'd3, 24'h0,      1'b0, 32'h0};
        v[6]  = '{2'd0, 5'd12, 1'b1, 4'hF, 4'hE, 4'd0, 24'h123456, 1'b1, 32'h2CFE_3456};
        v[7]  = '{2'd1, 5'd30, 1'b0, 4'd4, 4'd5, 4'd0, 24'hFF8001, 1'b1, 32'h5045_8001};
        v[8]  = '{2'd2, 5'd30, 1'b0, 4'd0, 4'd0, 4'd7, 24'hABCDEF, 1'b1, 32'h80AB_CDEF};
        v[9]  = '{2'd0, 5'd1,  1'b0, 4'd0, 4'd0, 4'hF, 24'hFFFFFF, 1'b1, 32'h0100_F000};
        v[10] = '{2'd2, 5'd1,  1'b1, 4'd9, 4'd0, 4'd0, 24'h000001, 1'b1, 32'hA000_0001};

        rst = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0; in_op = '0; in_cmd = '0;
        in_imm_flag = 1'b0; in_rd = '0; in_rn = '0; in_rm = '0; in_imm = '0;
        tick; tick;
        rst = 1'b0;
        in_valid = 1'b1;
        tick;
        chk("rst_we", imem_we, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_errs", {err_illegal, err_overflow}, 0);
        chk("rst_wcnt", word_count, 0);
        chk("idle_ready", in_ready, 0);
        in_valid = 1'b0;

        begin_prog;
        chk("load_ready", in_ready, 1);
        chk("load_busy", busy, 1);
        begin
            int e = 0;
            for (int i = 0; i < 11; i++) begin
                drive(v[i]);
                start = (i == 3);
                tick;
                chk($sformatf("vec%0d_we", i), imem_we, v[i].legal);
                if (v[i].legal) begin
                    chk($sformatf("vec%0d_addr", i), imem_addr, e);
                    chk($sformatf("vec%0d_data", i), imem_wdata, v[i].word);
                    e++;
                end
            end
        end
        start = 1'b0; in_valid = 1'b0;
        tick;
        chk("p1_wcnt", word_count, 9);
        chk("p1_ill", err_illegal, 1);
        chk("p1_ovf", err_overflow, 0);
        finish = 1'b1;
        tick;
        finish = 1'b0;
        chk("p1_pad_enter_we", imem_we, 0);
        for (int k = 0; k < 4; k++) begin
            tick;
            chk($sformatf("p1_nop%0d_we", k), imem_we, 1);
            chk($sformatf("p1_nop%0d_addr", k), imem_addr, 9 + k);
            chk($sformatf("p1_nop%0d_data", k), imem_wdata, 0);
            chk($sformatf("p1_nop%0d_done", k), done, 0);
        end
        tick;
        chk("p1_done", done, 1);
        chk("p1_busy", busy, 0);
        chk("p1_final_wcnt", word_count, 13);

        begin_prog;
        chk("p2_ill_cleared", err_illegal, 0);
        chk("p2_done_cleared", done, 0);
        for (int i = 0; i < 3; i++) begin
            drive(v[0]);
            in_rd = 4'(i);
            finish = (i == 2);
            tick;
            chk($sformatf("p2_w%0d_addr", i), imem_addr, i);
            chk($sformatf("p2_w%0d_data", i), imem_wdata, 32'h0402_3000 | (i << 20));
        end
        in_valid = 1'b0; finish = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick;
            chk($sformatf("p2_nop%0d", k), {imem_we, 26'(imem_addr), imem_wdata[4:0]}, {1'b1, 26'(3 + k), 5'd0});
        end
        tick;
        chk("p2_done", done, 1);
        chk("p2_wcnt", word_count, 7);
        drive(v[0]);
        finish = 1'b1;
        chk("done_ready", in_ready, 0);
        tick;
        chk("done_ignore_we", imem_we, 0);
        chk("done_ignore_wcnt", word_count, 7);
        chk("done_hold", done, 1);
        in_valid = 1'b0; finish = 1'b0;

        begin_prog;
        drive(v[0]);
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("fill%0d_ready", i), in_ready, 1);
            tick;
            chk($sformatf("fill%0d_addr", i), imem_addr, i);
        end
        chk("full_ready", in_ready, 0);
        tick;
        chk("full_we", imem_we, 0);
        chk("full_ovf", err_overflow, 1);
        in_valid = 1'b0; finish = 1'b1;
        tick;
        finish = 1'b0;
        chk("full_pad_done", done, 0);
        tick;
        chk("full_nopad_we", imem_we, 0);
        chk("full_done", done, 1);
        chk("full_wcnt", word_count, DEPTH);

        begin_prog;
        chk("p4_ovf_cleared", err_overflow, 0);
        drive(v[0]);
        for (int i = 0; i < DEPTH - 2; i++) tick;
        in_valid = 1'b0; finish = 1'b1;
        tick;
        finish = 1'b0;
        tick;
        chk("trunc_nop0", {imem_we, 26'(imem_addr)}, {1'b1, 26'd62});
        tick;
        chk("trunc_nop1", {imem_we, 26'(imem_addr)}, {1'b1, 26'd63});
        tick;
        chk("trunc_we", imem_we, 0);
        chk("trunc_done", done, 1);
        chk("trunc_wcnt", word_count, DEPTH);

        begin_prog;
        drive(v[2]);
        tick;
        drive(v[1]);
        tick;
        chk("pre_rst_we", imem_we, 1);
        rst = 1'b1;
        #1;
        chk("arst_we", imem_we, 0);
        chk("arst_outs", {busy, done, err_illegal, err_overflow, in_ready}, 0);
        chk("arst_addr_data", {26'(imem_addr), imem_wdata[5:0]} | 32'(word_count) | (|imem_wdata), 0);
        tick;
        rst = 1'b0; in_valid = 1'b0;
        tick;
        begin_prog;
        drive(v[3]);
        tick;
        in_valid = 1'b0;
        chk("restart_addr", {imem_we, 26'(imem_addr)}, {1'b1, 26'd0});
        chk("restart_data", imem_wdata, 32'hA000_0100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
